// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the LCD frame RAM write port between the renderer (0)
// and the waveform plotter (1). Define FB_ARB_FIXED_PRIORITY_EN for fixed priority to 0.
module fb_write_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_wren,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_G0   = 2'd1;
  localparam logic [1:0] ST_G1   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic              at_limit;
  logic              rel0, rel1;
  logic [1:0]        tie_st, rel0_st, rel1_st;

  assign ack0 = gnt0_q & req0;
  assign ack1 = gnt1_q & req1;

  assign cnt_inc  = count_q + CNT_W'(1);
  assign at_limit = (cnt_inc == CNT_MAX);
  assign rel0     = (state_q == ST_G0) && (!req0 || (ack0 && at_limit));
  assign rel1     = (state_q == ST_G1) && (!req1 || (ack1 && at_limit));

`ifdef FB_ARB_FIXED_PRIORITY_EN
  // Requester 0 always wins; a limit release with req0 still high re-grants it.
  assign tie_st  = ST_G0;
  assign rel0_st = req0 ? ST_G0 : (req1 ? ST_G1 : ST_IDLE);
  assign rel1_st = req0 ? ST_G0 : ST_IDLE;
`else
  logic last_q, last_d;

  assign tie_st  = last_q ? ST_G0 : ST_G1;
  assign rel0_st = req1 ? ST_G1 : ST_IDLE;
  assign rel1_st = req0 ? ST_G0 : ST_IDLE;

  always_comb begin
    last_d = last_q;
    if (rel0) begin
      last_d = 1'b0;
    end else if (rel1) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = tie_st;
        end else if (req0) begin
          state_d = ST_G0;
        end else if (req1) begin
          state_d = ST_G1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_G0: begin
        if (ack0) begin
          wren_d  = 1'b1;
          waddr_d = addr0;
          wdata_d = data0;
          count_d = cnt_inc;
        end else begin
          count_d = count_q;
        end
        if (rel0) begin
          count_d = '0;
          state_d = rel0_st;
        end else begin
          state_d = ST_G0;
        end
      end
      ST_G1: begin
        if (ack1) begin
          wren_d  = 1'b1;
          waddr_d = addr1;
          wdata_d = data1;
          count_d = cnt_inc;
        end else begin
          count_d = count_q;
        end
        if (rel1) begin
          count_d = '0;
          state_d = rel1_st;
        end else begin
          state_d = ST_G1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign gnt0_d = (state_d == ST_G0);
  assign gnt1_d = (state_d == ST_G1);
  assign busy_d = (state_d != ST_IDLE);

  // Async reset kills any in-flight write strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign ram_wren    = wren_q;
  assign ram_wr_addr = waddr_q;
  assign ram_wr_data = wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: random write streams, expected RAM write
// order from a burst-level arbitration model.
module tb_fb_write_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int MAXB = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wren, busy;

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ack0(ack0), .ack1(ack1),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_wren(ram_wren), .busy(busy)
  );

  always #5 clk = ~clk;

  word_t wq0[$], wq1[$], expq[$];
  int    n_chk = 0, n_fail = 0;
  int    wr_cnt = 0;
  int    ack_cnt0 = 0, ack_cnt1 = 0;
  int    gap1_after = -1;
  int    last_srv = 1;
  logic  [AW-1:0] last_a = '0;
  logic  acc0, acc1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected word.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_exclusive", int'(gnt0 & gnt1), 0);
      check("ack_exclusive", int'(ack0 & ack1), 0);
      if (ram_wren) begin
        if (expq.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          word_t w;
          w = expq.pop_front();
          check("wr_addr", int'(ram_wr_addr), int'(w.a));
          check("wr_data", int'(ram_wr_data), int'(w.d));
          last_a = w.a;
        end
        wr_cnt++;
      end else begin
        check("addr_hold", int'(ram_wr_addr), int'(last_a));
      end
    end
  end

  // Requester 0: holds req/addr/data until acked, advances on ack.
  initial begin
    req0 = 1'b0; addr0 = '0; data0 = '0;
    forever begin
      @(negedge clk); acc0 = ack0;
      @(posedge clk); #1;
      if (acc0 && wq0.size() > 0) begin wq0.delete(0); ack_cnt0++; end
      req0 = (wq0.size() > 0);
      if (req0) begin addr0 = wq0[0].a; data0 = wq0[0].d; end
    end
  end

  // Requester 1: same, plus an optional one-cycle req drop after a given ack count.
  initial begin
    req1 = 1'b0; addr1 = '0; data1 = '0;
    forever begin
      @(negedge clk); acc1 = ack1;
      @(posedge clk); #1;
      if (acc1 && wq1.size() > 0) begin wq1.delete(0); ack_cnt1++; end
      if (gap1_after >= 0 && ack_cnt1 == gap1_after) begin
        req1 = 1'b0;
        gap1_after = -1;
      end else begin
        req1 = (wq1.size() > 0);
        if (req1) begin addr1 = wq1[0].a; data1 = wq1[0].d; end
      end
    end
  end

  // Both streams start together; the model hands out whole bursts per the arbitration rules.
  task automatic push_phase(input int n0, input int n1, input logic fixed_a0);
    word_t t0[$], t1[$], w;
    int i0, i1, k, cur;
    for (int i = 0; i < n0; i++) begin
      w.a = fixed_a0 ? AW'(16 + i) : AW'($urandom);
      w.d = DW'($urandom);
      t0.push_back(w); wq0.push_back(w);
    end
    for (int i = 0; i < n1; i++) begin
      w.a = AW'($urandom); w.d = DW'($urandom);
      t1.push_back(w); wq1.push_back(w);
    end
    i0 = 0; i1 = 0;
`ifdef FB_ARB_FIXED_PRIORITY_EN
    cur = (n0 > 0) ? 0 : 1;
`else
    cur = (n0 > 0 && n1 > 0) ? ((last_srv == 0) ? 1 : 0) : ((n0 > 0) ? 0 : 1);
`endif
    while (i0 < n0 || i1 < n1) begin
      k = 0;
      while (k < MAXB && ((cur == 0) ? (i0 < n0) : (i1 < n1))) begin
        if (cur == 0) begin expq.push_back(t0[i0]); i0++; end
        else begin expq.push_back(t1[i1]); i1++; end
        k++;
      end
      last_srv = cur;
`ifdef FB_ARB_FIXED_PRIORITY_EN
      cur = (i0 < n0) ? 0 : 1;
`else
      if ((cur == 0) ? (i1 < n1) : (i0 < n0)) cur = 1 - cur;
`endif
    end
  endtask

  // Wait for the phase to drain; count write gaps and idle cycles inside it.
  task automatic wait_done(input string name, output int gaps, output int idles);
    int start, done;
    start = wr_cnt; gaps = 0; idles = 0; done = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (expq.size() == 0 && wq0.size() == 0 && wq1.size() == 0 && !busy) begin
        done = 1;
        break;
      end
      if (expq.size() > 0 && wr_cnt > start) begin
        if (!ram_wren) gaps++;
        if (!busy) idles++;
      end
    end
    check(name, done, 1);
  endtask

  initial begin
    int gaps, idles, base;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gnt0", int'(gnt0), 0);
    check("rst_gnt1", int'(gnt1), 0);
    check("rst_wren", int'(ram_wren), 0);
    check("rst_addr", int'(ram_wr_addr), 0);
    check("rst_data", int'(ram_wr_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ack", int'(ack0 | ack1), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single requester, 4 words at 0x010..0x013: latency and release timing.
    push_phase(4, 0, 1'b1);
    @(negedge clk); #1;
    check("c0_gnt0", int'(gnt0), 0);
    @(negedge clk); #1;
    check("c1_gnt0", int'(gnt0), 1);
    check("c1_wren", int'(ram_wren), 0);
    check("c1_ack0", int'(ack0), 1);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk); #1;
      check("burst_wren", int'(ram_wren), 1);
    end
    check("c5_busy", int'(busy), 1);
    @(negedge clk); #1;
    check("c6_wren", int'(ram_wren), 0);
    check("c6_busy", int'(busy), 0);
    check("c6_gnt0", int'(gnt0), 0);
    wait_done("drain_single", gaps, idles);

    push_phase(3, 5, 1'b0);
    wait_done("drain_short", gaps, idles);

    // Both streaming: bursts must abut with no write gaps.
    push_phase(48, 48, 1'b0);
    wait_done("drain_stream", gaps, idles);
`ifdef FB_ARB_FIXED_PRIORITY_EN
    check("stream_gaps", gaps, 3);
`else
    check("stream_gaps", gaps, 0);
`endif

    for (int p = 0; p < 8; p++) begin
      push_phase(int'($urandom_range(0, 40)), int'($urandom_range(1, 40)), 1'b0);
      wait_done("drain_random", gaps, idles);
    end

    // req1 drops for one cycle mid-grant: exactly one IDLE cycle before regrant.
    gap1_after = ack_cnt1 + 3;
    push_phase(0, 6, 1'b0);
    wait_done("drain_toggle", gaps, idles);
    check("toggle_idles", idles, 1);

    // Reset after the 7th accepted word of G1.
    base = ack_cnt1;
    push_phase(0, 20, 1'b0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 200; c++) begin
        @(posedge clk); #2;
        if (ack_cnt1 - base >= 7) begin seen = 1; break; end
      end
      check("reach_word7", seen, 1);
    end
    rst = 1'b1;
    #1;
    check("mid_rst_wren", int'(ram_wren), 0);
    check("mid_rst_gnt1", int'(gnt1), 0);
    check("mid_rst_busy", int'(busy), 0);
    wq0.delete(); wq1.delete(); expq.delete();
    last_srv = 1; last_a = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_phase(5, 5, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    check("tie_gnt0", int'(gnt0), 1);
    check("tie_gnt1", int'(gnt1), 0);
    wait_done("drain_after_rst", gaps, idles);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
